dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: posted-write store buffer with load forwarding,
// and a single-outstanding external bus for write drains and load misses.
module dmem_ctrl #(
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rena,
  input  logic        wena,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        sb_empty
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ST_BUSY, LD_BUSY, LD_DONE} state_e;

  state_e        state_q;
  logic          bus_req_q, bus_we_q;
  logic [31:0]   bus_addr_q, bus_wdata_q, ld_data_q;

  logic [29:0]   sb_addr_q [SB_DEPTH];
  logic [31:0]   sb_data_q [SB_DEPTH];
  logic [PW-1:0] head_q, tail_q, head_d, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          store, load, full, push, pop, hit, miss;
  logic [31:0]   hit_data;
  logic [PW-1:0] idx;
  logic          unused_lsbs;

  // Word accesses only: the byte offset never takes part in matching.
  assign unused_lsbs = ^addr[1:0];

  // A simultaneous load and store request is treated as a store.
  assign store = wena;
  assign load  = rena & ~wena;
  assign full  = (count_q == CW'(SB_DEPTH));
  assign push  = reset & store & ~full;
  assign pop   = reset & (state_q == ST_BUSY) & bus_ack;

  // Scan oldest to youngest so the last match is the youngest entry.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned, which would otherwise infer a latch.
    hit      = 1'b0;
    hit_data = 32'h0;
    idx      = head_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (sb_addr_q[idx] == addr[31:2])) begin
        hit      = 1'b1;
        hit_data = sb_data_q[idx];
      end
    end
  end

  assign miss = load & ~hit;

  always_comb begin
    stall = 1'b0;
    rdata = 32'h0;
    if (reset) begin
      if (store) stall = full;
      else       stall = miss & (state_q != LD_DONE);
      if (load && hit)             rdata = hit_data;
      else if (state_q == LD_DONE) rdata = ld_data_q;
    end
  end

  assign sb_empty  = ~reset | (count_q == '0);
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry storage has no reset; only slots inside the occupancy
  // window are ever read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr_q[tail_q] <= addr[31:2];
      sb_data_q[tail_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      ld_data_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            state_q    <= LD_BUSY;
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= {addr[31:2], 2'b00};
          end else if (count_q != '0) begin
            state_q     <= ST_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b1;
            bus_addr_q  <= {sb_addr_q[head_q], 2'b00};
            bus_wdata_q <= sb_data_q[head_q];
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        LD_BUSY: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            ld_data_q <= bus_rdata;
            state_q   <= LD_DONE;
          end
        end
        LD_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed scenarios plus randomized CPU/bus traffic,
// all compared each cycle against a queue-based behavioural model.
module tb_dmem_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        rena = 1'b0, wena = 1'b0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, bus_req, bus_we, sb_empty;

  dmem_ctrl #(.SB_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rena(rena),
    .wena(wena), .rdata(rdata), .stall(stall), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] d;
  } entry_t;

  // Model: pending stores in age order, the expected bus registers, and a
  // one-cycle "load data ready" flag.
  entry_t      sbq[$];
  logic        m_req, m_we, m_ld_ready;
  logic [31:0] m_addr, m_wdata, m_ld_data;

  int          n_checks = 0, n_pass = 0;
  logic        last_stall = 1'b0;
  logic        s_stall, s_bus_req, s_bus_we, s_sb_empty;
  logic [31:0] s_rdata, s_bus_addr, s_bus_wdata;
  logic [31:0] wr_log_a[$], wr_log_d[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    sbq.delete();
    m_req = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    m_ld_data = 32'h0; m_ld_ready = 1'b0;
  endtask

  task automatic model_lookup(output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'h0;
    if (rena && !wena)
      foreach (sbq[i])
        if (sbq[i].wa == addr[31:2]) begin
          hit = 1'b1;
          d   = sbq[i].d;
        end
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the
  // rising edge, return just after it so the caller can drive new inputs.
  task automatic step();
    logic        hit, full, ld, st, e_stall, done, push;
    logic [31:0] hd, e_rdata;
    entry_t      e;
    @(negedge clk);
    st   = wena;
    ld   = rena && !wena;
    full = (sbq.size() == DEPTH);
    model_lookup(hit, hd);
    if (!reset) begin
      e_stall = 1'b0;
      e_rdata = 32'h0;
    end else begin
      e_stall = st ? full : (ld && !hit && !m_ld_ready);
      e_rdata = (ld && hit) ? hd : (m_ld_ready ? m_ld_data : 32'h0);
    end
    s_stall = stall; s_rdata = rdata; s_sb_empty = sb_empty;
    s_bus_req = bus_req; s_bus_we = bus_we; s_bus_addr = bus_addr; s_bus_wdata = bus_wdata;
    check("stall", s_stall, e_stall);
    check("rdata", s_rdata, e_rdata);
    check("sb_empty", s_sb_empty, (!reset || sbq.size() == 0));
    check("bus_req", s_bus_req, m_req);
    if (m_req) begin
      check("bus_we", s_bus_we, m_we);
      check("bus_addr", s_bus_addr, m_addr);
      if (m_we) check("bus_wdata", s_bus_wdata, m_wdata);
    end
    if (reset && s_bus_req && s_bus_we && bus_ack) begin
      wr_log_a.push_back(s_bus_addr);
      wr_log_d.push_back(s_bus_wdata);
    end
    last_stall = e_stall;
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      done = m_req && bus_ack;
      push = st && !full;
      if (done) begin
        if (m_we) void'(sbq.pop_front());
        else begin
          m_ld_data  = bus_rdata;
          m_ld_ready = 1'b1;
        end
        m_req = 1'b0;
      end else if (m_ld_ready) begin
        m_ld_ready = 1'b0;
      end else if (!m_req) begin
        if (ld && !hit) begin
          m_req = 1'b1; m_we = 1'b0; m_addr = {addr[31:2], 2'b00};
        end else if (sbq.size() > 0) begin
          m_req = 1'b1; m_we = 1'b1;
          m_addr = {sbq[0].wa, 2'b00}; m_wdata = sbq[0].d;
        end
      end
      if (push) begin
        e.wa = addr[31:2];
        e.d  = wdata;
        sbq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic cpu_idle();
    rena = 1'b0; wena = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    rena = 1'b0; wena = 1'b1; addr = a; wdata = d;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    cpu_idle();
    bus_ack = 1'b1;
    while ((sbq.size() > 0 || m_req || m_ld_ready) && n < budget) begin
      step();
      n++;
    end
    step();
    check("drain_empty", s_sb_empty, 1);
    check("drain_idle_req", s_bus_req, 0);
  endtask

  initial begin
    int n, n0;
    model_reset();

    // Reset held two cycles with a store presented.
    reset = 1'b0;
    cpu_store(32'h40, 32'h1111_1111);
    repeat (2) begin
      step();
      check("rst_sb_empty", s_sb_empty, 1);
      check("rst_bus_req", s_bus_req, 0);
      check("rst_stall", s_stall, 0);
    end
    reset = 1'b1;
    cpu_idle();
    step();
    check("post_rst_sb_empty", s_sb_empty, 1);
    check("post_rst_bus_req", s_bus_req, 0);
    check("post_rst_stall", s_stall, 0);
    check("post_rst_bus_we", s_bus_we, 0);
    check("post_rst_bus_addr", s_bus_addr, 32'h0);
    check("post_rst_bus_wdata", s_bus_wdata, 32'h0);
    check("post_rst_rdata", s_rdata, 32'h0);

    // Forwarding of the youngest matching store.
    bus_ack = 1'b0;
    cpu_store(32'h10, 32'hDEAD_BEEF);
    step();
    cpu_store(32'h10, 32'hCAFE_F00D);
    step();
    wena = 1'b0; rena = 1'b1; addr = 32'h13;
    step();
    check("fwd_rdata", s_rdata, 32'hCAFE_F00D);
    check("fwd_stall", s_stall, 0);
    drain(50);

    // Minimum-latency load miss; ack already high before the request.
    cpu_idle();
    bus_ack = 1'b1;
    bus_rdata = 32'h1234_5678;
    rena = 1'b1; addr = 32'h20;
    step();
    check("miss_c1_stall", s_stall, 1);
    check("miss_c1_req", s_bus_req, 0);
    step();
    check("miss_c2_stall", s_stall, 1);
    check("miss_c2_req", s_bus_req, 1);
    check("miss_c2_we", s_bus_we, 0);
    check("miss_c2_addr", s_bus_addr, 32'h20);
    step();
    check("miss_c3_stall", s_stall, 0);
    check("miss_c3_rdata", s_rdata, 32'h1234_5678);
    check("miss_c3_req", s_bus_req, 0);
    cpu_idle();
    bus_ack = 1'b0;
    step();

    // Full buffer: fifth store waits for the first write to complete.
    for (int k = 0; k < 4; k++) begin
      cpu_store(32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
      step();
      check("full_accept_stall", s_stall, 0);
    end
    cpu_store(32'h110, 32'hA4);
    step();
    check("full_stall_a", s_stall, 1);
    step();
    check("full_stall_b", s_stall, 1);
    bus_ack = 1'b1;
    step();
    check("full_ack_stall", s_stall, 1);
    check("full_ack_req", s_bus_req, 1);
    check("full_ack_addr", s_bus_addr, 32'h100);
    bus_ack = 1'b0;
    step();
    check("full_release_stall", s_stall, 0);
    cpu_idle();
    step();
    check("full_not_empty", s_sb_empty, 0);
    drain(100);

    // Drain order with ack always high.
    wr_log_a.delete();
    wr_log_d.delete();
    bus_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cpu_store(32'(4 * k), 32'h5000 + 32'(k));
      step();
    end
    drain(50);
    check("drain_count", wr_log_a.size(), 3);
    for (int k = 0; k < 3 && k < wr_log_a.size(); k++) begin
      check("drain_order_addr", wr_log_a[k], 32'(4 * k));
      check("drain_order_data", wr_log_d[k], 32'h5000 + 32'(k));
    end

    // Reset while a write is outstanding.
    bus_ack = 1'b0;
    cpu_store(32'h200, 32'hB0);
    step();
    cpu_store(32'h204, 32'hB1);
    step();
    cpu_idle();
    n = 0;
    do begin
      step();
      n++;
    end while (!s_bus_req && n < 10);
    check("middrain_req_seen", s_bus_req, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("middrain_req_dropped", s_bus_req, 0);
    check("middrain_sb_empty", s_sb_empty, 1);
    bus_ack = 1'b1;
    n0 = wr_log_a.size();
    repeat (5) step();
    check("middrain_no_writes", wr_log_a.size(), n0);
    check("middrain_req_idle", s_bus_req, 0);

    // Randomized traffic; CPU holds its request while stalled.
    for (int c = 0; c < 3000; c++) begin
      if (!last_stall) begin
        int r;
        r = int'($urandom_range(0, 99));
        addr  = 32'h300 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
        wdata = $urandom;
        rena  = (r >= 40 && r < 80);
        wena  = (r < 40 || (r >= 75 && r < 80));
      end
      bus_ack   = ($urandom_range(0, 2) != 0);
      bus_rdata = $urandom;
      reset     = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1'b1;
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
